// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: register map, control/status
// bit positions and the responder FSM encoding.
package timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_BITS        = 3;

    localparam int STATUS_EXPIRED   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_DROP = 2'd2
    } resp_state_t;

endpackage

// File: rtl/timer_counter.sv
// Prescaler plus the COUNT/EXPIRED datapath. Bus writes to COUNT take priority
// over a tick on the same edge; a fresh expiry takes priority over a W1C clear.
module timer_counter
    import timer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PRESCALE   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  auto_reload,
    input  logic                  tick_kill,
    input  logic [DATA_WIDTH-1:0] load_value,
    input  logic                  count_we,
    input  logic [DATA_WIDTH-1:0] count_wdata,
    input  logic                  status_clr,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  expired,
    output logic                  tick,
    output logic                  stop_en
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;
    logic          tick_apply;
    logic          count_zero;

    assign tick       = en && (presc == PRESC_LAST);
    // A CTRL write that clears EN on the tick edge cancels that tick.
    assign tick_apply = tick && !tick_kill;
    assign count_zero = (count == '0);
    assign stop_en    = tick_apply && count_zero && !auto_reload;

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc   <= '0;
            count   <= '0;
            expired <= 1'b0;
        end else begin
            if (!en || presc == PRESC_LAST) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end

            if (count_we) begin
                count <= count_wdata;
            end else if (tick_apply) begin
                if (!count_zero) begin
                    count <= count - DATA_WIDTH'(1);
                end else if (auto_reload) begin
                    count <= load_value;
                end
            end

            if (tick_apply && count_zero) begin
                expired <= 1'b1;
            end else if (status_clr) begin
                expired <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mmio_timer_responder.sv
// Memory-mapped down-counting timer responding on the core's request/valid bus:
// address decode, responder FSM and the CTRL/LOAD register file.
module mmio_timer_responder
    import timer_pkg::*;
#(
    parameter int MEM_DEPTH  = 64,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int DATA_WIDTH = 32,
    parameter int BASE_ADDR  = 60,
    parameter int PRESCALE   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] Data_in,
    input  logic                  we,
    input  logic                  req_valid,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  data_valid,
    output logic                  irq
);

    // Handshake: the initiator holds addr/we/Data_in with req_valid high until it
    // sees data_valid; a hit is accepted only in IDLE, acknowledged by a single
    // data_valid pulse, and the next request needs req_valid low for a cycle.
    localparam logic [ADDR_WIDTH-1:0] BASE_VEC = ADDR_WIDTH'(BASE_ADDR);

    resp_state_t             state;
    resp_state_t             state_next;
    logic                    hit;
    logic                    accept;
    logic                    wr;
    logic [1:0]              reg_idx;
    logic [CTRL_BITS-1:0]    ctrl_q;
    logic [DATA_WIDTH-1:0]   load_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   rd_value;
    logic [DATA_WIDTH-1:0]   count;
    logic                    expired;
    logic                    tick;
    logic                    stop_en;
    logic                    wr_ctrl;

    assign hit     = req_valid && (addr[ADDR_WIDTH-1:2] == BASE_VEC[ADDR_WIDTH-1:2]);
    assign reg_idx = addr[1:0];
    assign accept  = (state == ST_IDLE) && hit;
    assign wr      = accept && we;
    assign wr_ctrl = wr && (reg_idx == REG_CTRL);

    timer_counter #(
        .DATA_WIDTH (DATA_WIDTH),
        .PRESCALE   (PRESCALE)
    ) u_counter (
        .clk         (clk),
        .reset       (reset),
        .en          (ctrl_q[CTRL_EN]),
        .auto_reload (ctrl_q[CTRL_AUTO_RELOAD]),
        .tick_kill   (wr_ctrl && !Data_in[CTRL_EN]),
        .load_value  (load_q),
        .count_we    (wr && (reg_idx == REG_COUNT)),
        .count_wdata (Data_in),
        .status_clr  (wr && (reg_idx == REG_STATUS) && Data_in[STATUS_EXPIRED]),
        .count       (count),
        .expired     (expired),
        .tick        (tick),
        .stop_en     (stop_en)
    );

    always_comb begin
        rd_value = '0;
        case (reg_idx)
            REG_CTRL:   rd_value[CTRL_BITS-1:0]   = ctrl_q;
            REG_LOAD:   rd_value                  = load_q;
            REG_COUNT:  rd_value                  = count;
            REG_STATUS: rd_value[STATUS_EXPIRED]  = expired;
            default:    rd_value                  = '0;
        endcase
    end

    // Read data is captured from pre-edge state; writes acknowledge with zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q  <= '0;
            load_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                rdata_q <= we ? '0 : rd_value;
            end
            if (wr_ctrl) begin
                ctrl_q <= Data_in[CTRL_BITS-1:0];
            end else if (stop_en) begin
                ctrl_q[CTRL_EN] <= 1'b0;
            end
            if (wr && (reg_idx == REG_LOAD)) begin
                load_q <= Data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (hit) state_next = ST_RESP;
            ST_RESP: state_next = ST_DROP;
            ST_DROP: if (!req_valid) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign data_valid = (state == ST_RESP);
    assign Data_out   = data_valid ? rdata_q : '0;
    assign irq        = expired && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Randomized bench for mmio_timer_responder: a behavioural timer model feeds an
// expected-response queue that a negedge monitor drains against the bus outputs.
module tb_mmio_timer_responder;

  localparam int MEM_DEPTH = 64;
  localparam int AW        = 6;
  localparam int DW        = 32;
  localparam int BASE      = 60;
  localparam int P         = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr;
  logic [DW-1:0] Data_in;
  logic          we;
  logic          req_valid;
  logic [DW-1:0] Data_out;
  logic          data_valid;
  logic          irq;

  mmio_timer_responder #(
    .MEM_DEPTH  (MEM_DEPTH),
    .DATA_WIDTH (DW),
    .BASE_ADDR  (BASE),
    .PRESCALE   (P)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .Data_in    (Data_in),
    .we         (we),
    .req_valid  (req_valid),
    .Data_out   (Data_out),
    .data_valid (data_valid),
    .irq        (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  logic [DW-1:0] exp_q[$];
  int            due_q[$];

  // behavioural model state
  bit            m_en, m_ar, m_ie, m_expired;
  logic [DW-1:0] m_load, m_count;
  int            m_phase;
  int            m_state;   // 0 waiting for a request, 1 answering, 2 waiting for release
  int            last_dv_cyc;

  task automatic check(input bit ok, input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_step();
    logic [DW-1:0] rd;
    logic [DW-1:0] n_count;
    bit            hit, acc, wr, tick, tick_ok, expire, n_en;
    int            idx;
    cyc++;
    if (!reset) begin
      m_en = 0; m_ar = 0; m_ie = 0; m_expired = 0;
      m_load = '0; m_count = '0; m_phase = 0; m_state = 0;
      exp_q.delete();
      due_q.delete();
    end else begin
      hit = req_valid && (int'(addr) / 4 == BASE / 4);
      idx = int'(addr) % 4;
      acc = (m_state == 0) && hit;
      wr  = acc && we;
      case (idx)
        0: rd = DW'(int'(m_en) + 2 * int'(m_ar) + 4 * int'(m_ie));
        1: rd = m_load;
        2: rd = m_count;
        default: rd = DW'(m_expired);
      endcase
      if (acc) begin
        exp_q.push_back(we ? '0 : rd);
        due_q.push_back(cyc);
      end
      if (m_state == 0) begin
        if (hit) m_state = 1;
      end else if (m_state == 1) begin
        m_state = 2;
      end else if (!req_valid) begin
        m_state = 0;
      end

      tick    = m_en && (m_phase == P - 1);
      tick_ok = tick && !(wr && idx == 0 && Data_in[0] == 1'b0);
      expire  = tick_ok && (m_count == 0);
      n_count = m_count;
      if (wr && idx == 2) n_count = Data_in;
      else if (tick_ok && m_count != 0) n_count = m_count - 1;
      else if (expire && m_ar) n_count = m_load;
      n_en = m_en;
      if (expire && !m_ar) n_en = 0;
      m_phase = m_en ? (m_phase + 1) % P : 0;
      if (expire) m_expired = 1;
      else if (wr && idx == 3 && Data_in[0]) m_expired = 0;
      if (wr && idx == 0) begin
        n_en = Data_in[0];
        m_ar = Data_in[1];
        m_ie = Data_in[2];
      end
      if (wr && idx == 1) m_load = Data_in;
      m_count = n_count;
      m_en    = n_en;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check(irq == (m_expired && m_ie), "irq", DW'(irq), DW'(m_expired && m_ie));
      if (data_valid) begin
        last_dv_cyc = cyc;
        if (exp_q.size() == 0) begin
          check(1'b0, "spurious_data_valid", Data_out, '0);
        end else begin
          check(Data_out == exp_q[0], "read_data", Data_out, exp_q[0]);
          check(cyc == due_q[0], "latency", DW'(cyc), DW'(due_q[0]));
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end else begin
        check(Data_out == '0, "idle_data_out", Data_out, '0);
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
          check(1'b0, "missing_response", '0, exp_q[0]);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_access(input int a, input bit w, input logic [DW-1:0] d,
                            input int hold, output logic [DW-1:0] rd);
    bit got = 0;
    rd = '0;
    addr = AW'(a); we = w; Data_in = d; req_valid = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (data_valid) begin
        got = 1;
        rd  = Data_out;
      end
    end
    if (!got) check(1'b0, "bus_timeout", '0, 32'h1);
    step();
    repeat (hold) step();
    req_valid = 1'b0;
    step();
  endtask

  task automatic bus_write(input int a, input logic [DW-1:0] d);
    logic [DW-1:0] unused_rd;
    bus_access(a, 1'b1, d, 0, unused_rd);
  endtask

  task automatic bus_read(input int a, output logic [DW-1:0] rd);
    bus_access(a, 1'b0, '0, 0, rd);
  endtask

  task automatic bus_miss(input int a);
    addr = AW'(a); we = $urandom_range(0, 1); Data_in = $urandom; req_valid = 1'b1;
    repeat (3) step();
    req_valid = 1'b0;
    step();
  endtask

  task automatic wait_irq(output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < 100 && at_cyc < 0; i++) begin
      @(negedge clk);
      if (irq) at_cyc = cyc;
    end
    check(at_cyc >= 0, "irq_timeout", DW'(irq), 32'h1);
  endtask

  task automatic sync_tick(input bit need_zero);
    for (int i = 0; i < 200; i++) begin
      if (m_en && m_phase == P - 1 && (!need_zero || m_count == 0)) break;
      step();
    end
  endtask

  initial begin
    logic [DW-1:0] rd;
    int t1, t2, t_acc;
    reset = 1'b0; req_valid = 1'b0; addr = '0; we = 1'b0; Data_in = '0;
    step();
    mon_en = 1'b1;
    step();
    step();
    reset = 1'b1;

    // registers read zero after reset; a miss is ignored
    for (int r = 0; r < 4; r++) begin
      bus_read(BASE + r, rd);
      check(rd == '0, "reset_reg", rd, '0);
    end
    bus_miss(0);

    // auto-reload period
    bus_write(BASE + 1, 3);
    bus_write(BASE + 0, 7);
    wait_irq(t1);
    step();
    bus_write(BASE + 3, 1);
    wait_irq(t2);
    check(t2 - t1 == (3 + 1) * P, "reload_period", DW'(t2 - t1), DW'((3 + 1) * P));
    step();
    for (int i = 0; i < 5; i++) bus_read(BASE + 2, rd);

    // one-shot expiry
    bus_write(BASE + 0, 0);
    bus_write(BASE + 3, 1);
    bus_write(BASE + 1, 2);
    bus_write(BASE + 2, 2);
    bus_write(BASE + 0, 5);
    t_acc = last_dv_cyc;
    wait_irq(t1);
    check(t1 - t_acc == 12, "oneshot_delay", DW'(t1 - t_acc), 32'd12);
    step();
    bus_read(BASE + 0, rd);
    check(rd == 32'h4, "oneshot_en_cleared", rd, 32'h4);
    bus_write(BASE + 3, 1);
    check(irq == 1'b0, "irq_cleared", DW'(irq), '0);

    // held request answered once
    bus_access(BASE + 1, 1'b0, '0, 10, rd);
    check(rd == 32'd2, "held_read", rd, 32'd2);

    // bus write to COUNT on the tick edge wins
    bus_write(BASE + 1, 3);
    bus_write(BASE + 0, 3);
    sync_tick(1'b0);
    bus_write(BASE + 2, 7);
    bus_read(BASE + 2, rd);
    check(rd == 32'd7, "count_write_on_tick", rd, 32'd7);

    // expiry beats a same-edge W1C
    bus_write(BASE + 0, 0);
    bus_write(BASE + 3, 1);
    bus_write(BASE + 2, 1);
    bus_write(BASE + 0, 3);
    sync_tick(1'b1);
    bus_write(BASE + 3, 1);
    bus_read(BASE + 3, rd);
    check(rd == 32'd1, "expire_beats_w1c", rd, 32'd1);

    // reset during the response cycle, then reset on an accepting edge
    bus_write(BASE + 1, 32'h55);
    addr = AW'(BASE + 1); we = 1'b0; req_valid = 1'b1;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1; req_valid = 1'b0;
    step();
    addr = AW'(BASE + 2); req_valid = 1'b1; reset = 1'b0;
    step();
    reset = 1'b1; req_valid = 1'b0;
    step();
    for (int r = 0; r < 4; r++) begin
      bus_read(BASE + r, rd);
      check(rd == '0, "post_reset_reg", rd, '0);
    end

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      int sel = $urandom_range(0, 9);
      int idx = $urandom_range(0, 3);
      logic [DW-1:0] d;
      if (sel == 0) begin
        bus_miss($urandom_range(0, BASE - 1));
      end else begin
        case (idx)
          0: d = ($urandom & 32'hFFFF_FFF8) | DW'($urandom_range(0, 7));
          1: d = DW'($urandom_range(0, 6));
          2: d = DW'($urandom_range(0, 6));
          default: d = DW'($urandom_range(0, 1));
        endcase
        bus_access(BASE + idx, sel > 5, d, $urandom_range(0, 2), rd);
      end
    end

    repeat (5) step();
    check(exp_q.size() == 0, "queue_drained", DW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
